lsu_ctrl: RTL
=============

Name: lsu_ctrl

Overview:
- Load/store unit controller; the consumer end of the decoder's `O_ls_valid`/`O_ls_type` access interface.
- Takes one decoded memory access at a time and computes the word address, byte strobes and aligned write data.
- Runs a valid/ready request plus response handshake to the data memory port.
- Returns sign/zero-extended load data to the register-file writeback path, or a misalignment flag.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; fixed at 32, other values unsupported.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- I_ls_valid  in  1  access request from the ID/EX stage.
- I_ls_type  in  4  access type: nop=0, lb=1, lh=2, lw=3, lbu=4, lhu=5, sb=6, sh=7, sw=8; codes 9-15 are illegal.
- I_addr  in  ADDR_W  effective byte address (AGU result).
- I_wdata  in  32  store data (rs2).
- I_rd_waddr  in  5  load destination register.
- O_ready  out  1  unit idle, access accepted this cycle.
- O_mem_req_valid  out  1  memory request valid.
- I_mem_req_ready  in  1  memory accepts the request.
- O_mem_addr  out  ADDR_W  word-aligned address, {I_addr[31:2], 2'b00}.
- O_mem_we  out  1  1 = store.
- O_mem_wstrb  out  4  byte-lane strobes.
- O_mem_wdata  out  32  lane-replicated store data.
- I_mem_rsp_valid  in  1  response (read data or write ack).
- I_mem_rsp_rdata  in  32  read word.
- O_done  out  1  one-cycle completion pulse.
- O_rd_we  out  1  register writeback enable.
- O_rd_waddr  out  5  writeback register.
- O_rd_wdata  out  32  extended load data.
- O_misalign  out  1  misaligned access, qualified by O_done.

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0 except O_ready=1.
- States and transitions:
  - IDLE -> REQ on accept of an aligned access.
  - IDLE -> DONE on accept of a misaligned access.
  - REQ -> RSP on the handshake cycle (`O_mem_req_valid & I_mem_req_ready`).
  - RSP -> DONE on I_mem_rsp_valid.
  - DONE -> IDLE unconditionally.
- Accept: O_ready is 1 only in IDLE. Accept occurs when O_ready & I_ls_valid & type in 1..8. Type 0 or 9-15 is never accepted and the unit stays IDLE. I_ls_valid outside IDLE is ignored; upstream holds the request until accepted.
- Capture on accept: type, addr, wdata and rd are registered. Outputs derive only from registered values, so inputs may change after accept.
- Misalign rule:
  - lh/lhu/sh with addr[0]=1 is misaligned.
  - lw/sw with addr[1:0]!=0 is misaligned.
  - Byte accesses are never misaligned.
  - On misalign: no memory request is issued; DONE with O_misalign=1, O_rd_we=0.
- REQ state: O_mem_req_valid=1. Addr, we, wstrb and wdata are held stable until I_mem_req_ready. Arbitrary wait is allowed.
- Strobes (off = addr[1:0]):
  - sb: 4'b0001<<off.
  - sh: 4'b0011<<off.
  - sw: 4'b1111.
  - loads: 4'b0000.
- Store data: sb -> {4{wdata[7:0]}}; sh -> {2{wdata[15:0]}}; sw -> wdata. O_mem_wdata=0 for loads.
- RSP state: wait for I_mem_rsp_valid. A response in the same cycle as the request handshake is not legal and is ignored; the earliest legal response is the cycle after the handshake. I_mem_rsp_valid in IDLE, REQ or DONE is ignored.
- On response, shift = rdata >> (8*off), then:
  - lb: sign-extend [7:0].
  - lbu: zero-extend [7:0].
  - lh: sign-extend [15:0].
  - lhu: zero-extend [15:0].
  - lw: whole word.
  - The result is registered.
- DONE state (exactly 1 cycle): O_done=1.
  - Loads: O_rd_we=1 iff rd!=0, with O_rd_waddr=rd and O_rd_wdata=result.
  - Stores: O_rd_we=0.
  - O_done, O_rd_we and O_misalign are 0 in all other states. O_rd_wdata and O_rd_waddr are 0 outside DONE.
- Latency:
  - Aligned access, ready and rsp with no wait: 3 cycles, accept edge -> O_done.
  - Misaligned: 1 cycle.
  - A new access may be accepted the cycle after DONE.
- Reset mid-operation: an outstanding request is dropped immediately (O_mem_req_valid -> 0) and the unit returns to IDLE. A late response after reset arrives in IDLE and is ignored.

Test Plan:
1. lw, addr=0x80000004, rsp rdata=0xDEADBEEF, ready/rsp with no wait -> mem addr 0x80000004, wstrb 0, O_done 3 cycles after accept, O_rd_wdata=0xDEADBEEF, O_rd_we=1.
2. lb/lbu at addr=0x80000003, rdata=0x80FF7F01 -> lb gives 0xFFFFFF80, lbu gives 0x00000080; lh at 0x80000002 gives 0xFFFF80FF.
3. sb at addr=0x10000001 with wdata=0x12345678 -> wstrb 4'b0010, wdata 0x78787878, we=1, O_rd_we=0 at done; sh at 0x10000002 -> wstrb 4'b1100, wdata 0x56785678.
4. I_mem_req_ready low for 5 cycles, then rsp delayed 4 cycles -> req_valid, addr and wstrb stable throughout, O_ready=0, a second I_ls_valid is ignored, exactly one O_done.
5. lw at 0x...2 and sh at 0x...1 -> no O_mem_req_valid, O_done+O_misalign 1 cycle after accept, O_rd_we=0; lw with rd=0 -> O_done=1, O_rd_we=0.
6. rst asserted in REQ and in RSP, then a stray I_mem_rsp_valid -> outputs at reset values, O_done never pulses, the next lw completes normally.

Source files
------------

// File: rtl/lsu_mem_if.sv
// Data-memory port of the load/store unit: a request channel with a valid/ready
// handshake, plus a response channel carrying read data or a write acknowledge.
interface lsu_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              O_mem_req_valid;
  logic              I_mem_req_ready;
  logic [ADDR_W-1:0] O_mem_addr;
  logic              O_mem_we;
  logic [3:0]        O_mem_wstrb;
  logic [DATA_W-1:0] O_mem_wdata;
  logic              I_mem_rsp_valid;
  logic [DATA_W-1:0] I_mem_rsp_rdata;

  modport master (
    output O_mem_req_valid, O_mem_addr, O_mem_we, O_mem_wstrb, O_mem_wdata,
    input  I_mem_req_ready, I_mem_rsp_valid, I_mem_rsp_rdata
  );

  modport slave (
    input  O_mem_req_valid, O_mem_addr, O_mem_we, O_mem_wstrb, O_mem_wdata,
    output I_mem_req_ready, I_mem_rsp_valid, I_mem_rsp_rdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one decoded access at a time, drives the
// data-memory handshake and returns extended load data or a misalignment flag.
module lsu_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              I_ls_valid,
  input  logic [3:0]        I_ls_type,
  input  logic [ADDR_W-1:0] I_addr,
  input  logic [DATA_W-1:0] I_wdata,
  input  logic [4:0]        I_rd_waddr,
  output logic              O_ready,
  lsu_mem_if.master         mem,
  output logic              O_done,
  output logic              O_rd_we,
  output logic [4:0]        O_rd_waddr,
  output logic [DATA_W-1:0] O_rd_wdata,
  output logic              O_misalign
);

  localparam logic [3:0] T_LB  = 4'd1;
  localparam logic [3:0] T_LH  = 4'd2;
  localparam logic [3:0] T_LW  = 4'd3;
  localparam logic [3:0] T_LBU = 4'd4;
  localparam logic [3:0] T_LHU = 4'd5;
  localparam logic [3:0] T_SB  = 4'd6;
  localparam logic [3:0] T_SH  = 4'd7;
  localparam logic [3:0] T_SW  = 4'd8;

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

  state_t            state, state_nxt;
  logic              accept;
  logic [3:0]        type_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [4:0]        rd_p0;
  logic [DATA_W-1:0] result_p1;

  function automatic logic is_load(input logic [3:0] t);
    return (t >= T_LB) && (t <= T_LHU);
  endfunction

  function automatic logic is_store(input logic [3:0] t);
    return (t >= T_SB) && (t <= T_SW);
  endfunction

  function automatic logic misaligned(input logic [3:0] t, input logic [1:0] off);
    logic m;
    case (t)
      T_LH, T_LHU, T_SH: m = off[0];
      T_LW, T_SW:        m = (off != 2'b00);
      default:           m = 1'b0;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] strobe(input logic [3:0] t, input logic [1:0] off);
    logic [3:0] s;
    case (t)
      T_SB:    s = 4'b0001 << off;
      T_SH:    s = 4'b0011 << off;
      T_SW:    s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] store_data(input logic [3:0] t,
                                                   input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] d;
    case (t)
      T_SB:    d = {4{w[7:0]}};
      T_SH:    d = {2{w[15:0]}};
      T_SW:    d = w;
      default: d = '0;
    endcase
    return d;
  endfunction

  // Lane-select the addressed byte/half down to bit 0, then extend by type.
  function automatic logic [DATA_W-1:0] extend_load(input logic [3:0] t,
                                                    input logic [1:0] off,
                                                    input logic [DATA_W-1:0] rdata);
    logic [DATA_W-1:0] sh, r;
    sh = rdata >> {off, 3'b000};
    case (t)
      T_LB:    r = {{(DATA_W-8){sh[7]}}, sh[7:0]};
      T_LBU:   r = {{(DATA_W-8){1'b0}}, sh[7:0]};
      T_LH:    r = {{(DATA_W-16){sh[15]}}, sh[15:0]};
      T_LHU:   r = {{(DATA_W-16){1'b0}}, sh[15:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

  assign accept = (state == IDLE) && I_ls_valid &&
                  (I_ls_type != 4'd0) && (I_ls_type <= T_SW);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Stage p0: access captured at accept; stage p1: extended load result.
  always_ff @(posedge clk) begin
    if (accept) begin
      type_p0  <= I_ls_type;
      addr_p0  <= I_addr;
      wdata_p0 <= I_wdata;
      rd_p0    <= I_rd_waddr;
    end
    if (state == RSP && mem.I_mem_rsp_valid)
      result_p1 <= extend_load(type_p0, addr_p0[1:0], mem.I_mem_rsp_rdata);
  end

  always_comb begin
    state_nxt           = state;
    O_ready             = 1'b0;
    mem.O_mem_req_valid = 1'b0;
    mem.O_mem_addr      = '0;
    mem.O_mem_we        = 1'b0;
    mem.O_mem_wstrb     = 4'b0000;
    mem.O_mem_wdata     = '0;
    O_done              = 1'b0;
    O_rd_we             = 1'b0;
    O_rd_waddr          = 5'd0;
    O_rd_wdata          = '0;
    O_misalign          = 1'b0;
    case (state)
      IDLE: begin
        O_ready = 1'b1;
        if (accept)
          state_nxt = misaligned(I_ls_type, I_addr[1:0]) ? DONE : REQ;
      end
      REQ: begin
        mem.O_mem_req_valid = 1'b1;
        mem.O_mem_addr      = {addr_p0[ADDR_W-1:2], 2'b00};
        mem.O_mem_we        = is_store(type_p0);
        mem.O_mem_wstrb     = strobe(type_p0, addr_p0[1:0]);
        mem.O_mem_wdata     = store_data(type_p0, wdata_p0);
        if (mem.I_mem_req_ready) state_nxt = RSP;
      end
      RSP: begin
        if (mem.I_mem_rsp_valid) state_nxt = DONE;
      end
      DONE: begin
        O_done     = 1'b1;
        O_misalign = misaligned(type_p0, addr_p0[1:0]);
        if (is_load(type_p0) && !O_misalign) begin
          O_rd_we    = (rd_p0 != 5'd0);
          O_rd_waddr = rd_p0;
          O_rd_wdata = result_p1;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
